// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port between the memory-stage controller and the data cache.
// Latency: none, plain wires; the cache answers with dhit in the same cycle it completes.
// Backpressure: the request is held until dhit; the controller stalls upstream meanwhile.
interface mem_stage_ctrl_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  // Controller side: issues requests, receives completion and load data.
  modport master (
    output dmemREN,
    output dmemWEN,
    output dmemaddr,
    output dmemstore,
    input  dhit,
    input  dmemload
  );

  // Cache side: receives requests, reports completion and load data.
  modport slave (
    input  dmemREN,
    input  dmemWEN,
    input  dmemaddr,
    input  dmemstore,
    output dhit,
    output dmemload
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores from EX/MEM, fills MEM/WB, latches HALT.
// Latency: 1 cycle to MEM/WB on a cache hit; each miss cycle adds one stall and one bubble.
// Backpressure: mem_stall freezes the upstream pipeline while a request waits for dhit.
module mem_stage_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             memtoreg_in,
  input  logic                   regwrite_in,
  input  logic                   dmemREN_in,
  input  logic                   dmemWEN_in,
  input  logic                   halt_in,
  input  logic [31:0]            aluResult_in,
  input  logic [31:0]            rdat2_in,
  input  logic [31:0]            npc_in,
  input  logic [31:0]            upper16_in,
  input  logic [4:0]             branchDest_in,
  mem_stage_ctrl_if.master       dmem,
  output logic                   mem_stall,
  output logic                   wb_regwrite,
  output logic [4:0]             wb_dest,
  output logic [31:0]            wb_data,
  output logic                   wb_halt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  state_t      state;
  state_t      next_state;
  logic        req;
  logic [31:0] wb_sel;

  // State register; reset always returns to IDLE, dropping any pending request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request generation, stall and next state. A halted core issues nothing.
  always_comb begin
    next_state      = state;
    req             = 1'b0;
    dmem.dmemREN    = 1'b0;
    dmem.dmemWEN    = 1'b0;
    dmem.dmemaddr   = 32'h0;
    dmem.dmemstore  = 32'h0;
    mem_stall       = 1'b0;

    if (state != HALTED) begin
      req = dmemREN_in | dmemWEN_in;
    end

    if (req) begin
      // A store takes priority when both enables are set.
      dmem.dmemWEN   = dmemWEN_in;
      dmem.dmemREN   = dmemREN_in & ~dmemWEN_in;
      dmem.dmemaddr  = aluResult_in;
      dmem.dmemstore = rdat2_in;
    end

    mem_stall = req & ~dmem.dhit;

    unique case (state)
      IDLE: begin
        if (mem_stall) begin
          next_state = WAIT;
        end else if (halt_in) begin
          next_state = HALTED;
        end
      end
      WAIT: begin
        // Inputs are frozen while stalled; leaving on a lost request is only a safety net.
        if (dmem.dhit || !req) begin
          next_state = halt_in ? HALTED : IDLE;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Write-back source select; load data is only meaningful in the dhit cycle,
  // which is the only cycle a load can reach MEM/WB without stalling.
  always_comb begin
    wb_sel = aluResult_in;
    unique case (memtoreg_in)
      2'b00: wb_sel = aluResult_in;
      2'b01: wb_sel = dmem.dmemload;
      2'b10: wb_sel = npc_in;
      2'b11: wb_sel = upper16_in;
      default: wb_sel = aluResult_in;
    endcase
  end

  // MEM/WB register: capture when flowing, bubble when stalled, park when halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_regwrite <= 1'b0;
      wb_dest     <= 5'd0;
      wb_data     <= 32'h0;
      wb_halt     <= 1'b0;
    end else if (state == HALTED) begin
      wb_regwrite <= 1'b0;
      wb_halt     <= 1'b1;
    end else if (mem_stall) begin
      wb_regwrite <= 1'b0;
    end else begin
      wb_regwrite <= regwrite_in;
      wb_dest     <= branchDest_in;
      wb_data     <= wb_sel;
      wb_halt     <= halt_in;
    end
  end

  // Saturating count of stalled cycles for performance debug.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (mem_stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios followed by random transactions.
// Latency: model expects MEM/WB one edge after a non-stalled cycle.
// Backpressure: miss latency is randomised and inputs are held while stalled.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  memtoreg_in;
  logic        regwrite_in;
  logic        dmemREN_in;
  logic        dmemWEN_in;
  logic        halt_in;
  logic [31:0] aluResult_in;
  logic [31:0] rdat2_in;
  logic [31:0] npc_in;
  logic [31:0] upper16_in;
  logic [4:0]  branchDest_in;
  logic        mem_stall;
  logic        wb_regwrite;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_halt;
  logic [3:0]  stall_cnt;

  mem_stage_ctrl_if dif ();

  mem_stage_ctrl #(.STALL_CNT_W(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .memtoreg_in   (memtoreg_in),
    .regwrite_in   (regwrite_in),
    .dmemREN_in    (dmemREN_in),
    .dmemWEN_in    (dmemWEN_in),
    .halt_in       (halt_in),
    .aluResult_in  (aluResult_in),
    .rdat2_in      (rdat2_in),
    .npc_in        (npc_in),
    .upper16_in    (upper16_in),
    .branchDest_in (branchDest_in),
    .dmem          (dif),
    .mem_stall     (mem_stall),
    .wb_regwrite   (wb_regwrite),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .wb_halt       (wb_halt),
    .stall_cnt     (stall_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: architectural view of the stage (halted flag, MEM/WB, counter).
  bit          m_halted   = 1'b0;
  logic        m_regwrite = 1'b0;
  logic [4:0]  m_dest     = 5'd0;
  logic [31:0] m_data     = 32'h0;
  logic        m_halt     = 1'b0;
  int          m_cnt      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wb_value();
    case (memtoreg_in)
      2'b00:   return aluResult_in;
      2'b01:   return dif.dmemload;
      2'b10:   return npc_in;
      default: return upper16_in;
    endcase
  endfunction

  task automatic clear_inputs();
    memtoreg_in   = 2'b00;
    regwrite_in   = 1'b0;
    dmemREN_in    = 1'b0;
    dmemWEN_in    = 1'b0;
    halt_in       = 1'b0;
    aluResult_in  = 32'h0;
    rdat2_in      = 32'h0;
    npc_in        = 32'h0;
    upper16_in    = 32'h0;
    branchDest_in = 5'd0;
    dif.dhit      = 1'b0;
    dif.dmemload  = 32'h0;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic cyc();
    bit req_e;
    bit stall_e;
    #3;
    req_e   = !m_halted && (dmemREN_in || dmemWEN_in);
    stall_e = req_e && !dif.dhit;
    check("dmemWEN",   32'(dif.dmemWEN), 32'(req_e && dmemWEN_in));
    check("dmemREN",   32'(dif.dmemREN), 32'(req_e && dmemREN_in && !dmemWEN_in));
    check("dmemaddr",  dif.dmemaddr,     req_e ? aluResult_in : 32'h0);
    check("dmemstore", dif.dmemstore,    req_e ? rdat2_in : 32'h0);
    check("mem_stall", 32'(mem_stall),   32'(stall_e));
    @(posedge CLK);
    if (RST) begin
      m_halted = 1'b0; m_regwrite = 1'b0; m_dest = 5'd0; m_data = 32'h0;
      m_halt = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      m_regwrite = 1'b0;
      m_halt     = 1'b1;
    end else if (stall_e) begin
      m_regwrite = 1'b0;
      if (m_cnt < 15) m_cnt++;
    end else begin
      m_regwrite = regwrite_in;
      m_dest     = branchDest_in;
      m_data     = wb_value();
      m_halt     = halt_in;
      if (halt_in) m_halted = 1'b1;
    end
    #1;
    check("wb_regwrite", 32'(wb_regwrite), 32'(m_regwrite));
    check("wb_dest",     32'(wb_dest),     32'(m_dest));
    check("wb_data",     wb_data,          m_data);
    check("wb_halt",     32'(wb_halt),     32'(m_halt));
    check("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
  endtask

  task automatic randomize_instr();
    memtoreg_in   = 2'($urandom_range(0, 3));
    regwrite_in   = 1'($urandom_range(0, 1));
    dmemREN_in    = ($urandom_range(0, 2) == 0);
    dmemWEN_in    = ($urandom_range(0, 3) == 0);
    halt_in       = ($urandom_range(0, 29) == 0);
    aluResult_in  = $urandom;
    rdat2_in      = $urandom;
    npc_in        = $urandom;
    upper16_in    = $urandom;
    branchDest_in = 5'($urandom_range(0, 31));
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_cnt", 32'(stall_cnt), 32'h0);
    RST = 1'b0;

    // ALU op, no memory access.
    memtoreg_in = 2'b00; regwrite_in = 1'b1; aluResult_in = 32'h1234; branchDest_in = 5'd5;
    cyc();
    check("alu_wb_data", wb_data, 32'h1234);
    check("alu_wb_dest", 32'(wb_dest), 32'd5);

    // Load with a 3-cycle miss.
    clear_inputs();
    dmemREN_in = 1'b1; regwrite_in = 1'b1; aluResult_in = 32'h80; memtoreg_in = 2'b01;
    branchDest_in = 5'd7;
    for (int k = 0; k < 2; k++) begin
      dif.dmemload = $urandom;
      cyc();
      check("ld_bubble", 32'(wb_regwrite), 32'h0);
    end
    dif.dhit = 1'b1; dif.dmemload = 32'hDEADBEEF;
    cyc();
    check("ld_data", wb_data, 32'hDEADBEEF);
    check("ld_cnt", 32'(stall_cnt), 32'd2);

    // Store and load both asserted, immediate hit.
    clear_inputs();
    dmemREN_in = 1'b1; dmemWEN_in = 1'b1; rdat2_in = 32'hCAFEF00D; aluResult_in = 32'h40;
    dif.dhit = 1'b1;
    cyc();
    check("st_cnt_unchanged", 32'(stall_cnt), 32'd2);

    // HALT behind a store that stalls for 2 cycles.
    clear_inputs();
    dmemWEN_in = 1'b1; rdat2_in = 32'h11112222; aluResult_in = 32'h100; halt_in = 1'b1;
    cyc();
    cyc();
    check("halt_not_yet", 32'(wb_halt), 32'h0);
    dif.dhit = 1'b1;
    cyc();
    check("halt_set", 32'(wb_halt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      dif.dhit = 1'($urandom_range(0, 1));
      halt_in  = 1'b0;
      cyc();
    end
    check("halt_sticky", 32'(wb_halt), 32'h1);

    // Reset while a load waits.
    RST = 1'b1; cyc(); RST = 1'b0;
    clear_inputs();
    dmemREN_in = 1'b1; memtoreg_in = 2'b01; regwrite_in = 1'b1; aluResult_in = 32'h200;
    cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    clear_inputs();
    dif.dhit = 1'b1; dif.dmemload = 32'h55AA55AA;
    cyc();
    check("rst_wait_data", wb_data, 32'h0);

    // Counter saturation with 20 stall cycles.
    clear_inputs();
    dmemREN_in = 1'b1; aluResult_in = 32'h300;
    for (int k = 0; k < 20; k++) cyc();
    dif.dhit = 1'b1;
    cyc();
    check("cnt_sat", 32'(stall_cnt), 32'hF);

    // Random transactions with random miss latency.
    RST = 1'b1; clear_inputs(); cyc(); RST = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 39) == 0 || (m_halted && $urandom_range(0, 3) == 0)) begin
        RST = 1'b1;
        randomize_instr();
        cyc();
        RST = 1'b0;
      end else begin
        int lat;
        randomize_instr();
        lat = (dmemREN_in || dmemWEN_in) ? $urandom_range(0, 3) : 0;
        for (int k = 0; k < lat; k++) begin
          dif.dhit = 1'b0; dif.dmemload = $urandom;
          cyc();
        end
        dif.dhit = (dmemREN_in || dmemWEN_in) ? 1'b1 : 1'($urandom_range(0, 1));
        dif.dmemload = $urandom;
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
